// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and
// the default debounce timer width.
package debounce_pkg;

  // Default timer width; the settling window is 2^N-1 clock cycles.
  localparam int DEFAULT_N = 20;

  // Debouncer states: two stable levels and one settling window toward each.
  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous 1-bit level into the clk
// domain. Both flops clear to 0 on the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_tick.sv
// Switch debouncer: a synchronized input must hold a new level for a full
// 2^N-1 cycle window before the debounced level follows it. A one-cycle
// db_tick marks every debounced rising transition.
module debounce_tick
  import debounce_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  localparam logic [N-1:0] TIMER_MAX  = {N{1'b1}};
  localparam logic [N-1:0] TIMER_ZERO = {N{1'b0}};
  localparam logic [N-1:0] TIMER_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic          sw_s;
  state_t        state;
  state_t        state_next;
  logic [N-1:0]  timer;
  logic [N-1:0]  timer_next;
  logic          tick_next;
  logic          level_next;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  // Next-state, window timer and rising-edge tick decode.
  always_comb begin
    state_next = state;
    timer_next = timer;
    tick_next  = 1'b0;
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          timer_next = TIMER_MAX;
        end else begin
          state_next = ZERO;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          // Reversal aborts the window; the next attempt reloads it fully.
          state_next = ZERO;
          timer_next = TIMER_ZERO;
        end else if (timer == TIMER_ZERO) begin
          state_next = ONE;
          tick_next  = 1'b1;
        end else begin
          timer_next = timer - TIMER_ONE;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          timer_next = TIMER_MAX;
        end else begin
          state_next = ONE;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          // Glitch low while high: return to ONE silently, no tick.
          state_next = ONE;
          timer_next = TIMER_ZERO;
        end else if (timer == TIMER_ZERO) begin
          state_next = ZERO;
        end else begin
          timer_next = timer - TIMER_ONE;
        end
      end
      default: begin
        state_next = ZERO;
        timer_next = TIMER_ZERO;
      end
    endcase
  end

  // Debounced level is high in ONE and WAIT0 (the window toward zero).
  always_comb begin
    level_next = (state_next == ONE) || (state_next == WAIT0);
  end

  // State, timer and registered outputs; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ZERO;
      timer    <= TIMER_ZERO;
      db_tick  <= 1'b0;
      db_level <= 1'b0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      db_tick  <= tick_next;
      db_level <= level_next;
    end
  end

endmodule
